// File: rtl/frame_wr_packer.sv
// -----------------------------------------------------------------------------
// frame_wr_packer
//
// Purpose:
//   Write-side producer for the frame buffer. This block packs a narrow pixel
//   stream (valid/ready, with a start-of-frame flag) into DATA_WIDTH words. It
//   drives the buffer's active-low write strobe and write data. One frame is
//   FRAME_WORDS words long. The buffer derives its addresses from the strobes.
//
// Optional feature (macro FRAME_WR_EOF_EN):
//   Defining this macro adds the pix_eof input. A pix_eof transfer closes the
//   frame early: it writes the zero-padded partial word and goes to DONE.
//   Without the macro, every frame is exactly FRAME_WORDS words long.
//
// Ports:
//   wr_clk        in   write clock, all logic on posedge
//   reset         in   synchronous, active-high
//   pix_valid     in   pixel present on pix_data
//   pix_data      in   pixel value (PIX_WIDTH)
//   pix_sof       in   first pixel of a frame, qualified by pix_valid
//   pix_eof       in   last pixel of a frame (FRAME_WR_EOF_EN only)
//   pix_ready     out  pixel accepted when pix_valid & pix_ready
//   buf_wr_en_n   out  active-low write strobe, one cycle per word
//   buf_data      out  packed word, valid while buf_wr_en_n == 0
//   words_written out  words written in the current frame (ADDR_WIDTH+1)
//   frame_done    out  one-cycle pulse after the last word of a frame
//   sof_err       out  one-cycle pulse when pix_sof arrives mid-frame
//   state_dbg     out  current FSM state (IDLE=0, PACK=1, DONE=2)
//
// Handshake: a pixel transfers on a posedge where pix_valid and pix_ready are
// both high. pix_ready is registered, so it never depends on pix_valid.
// -----------------------------------------------------------------------------
module frame_wr_packer #(
    parameter int PIX_WIDTH   = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int FRAME_WORDS = 1 << ADDR_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [PIX_WIDTH-1:0]  pix_data,
    input  logic                  pix_sof,
`ifdef FRAME_WR_EOF_EN
    input  logic                  pix_eof,
`endif
    output logic                  pix_ready,
    output logic                  buf_wr_en_n,
    output logic [DATA_WIDTH-1:0] buf_data,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  frame_done,
    output logic                  sof_err,
    output logic [1:0]            state_dbg
);

    localparam int PPW   = DATA_WIDTH / PIX_WIDTH;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX      = IDX_W'(PPW - 1);
    localparam logic [ADDR_WIDTH:0] FRAME_WORDS_C = (ADDR_WIDTH + 1)'(FRAME_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic                  ready_q, ready_d;
    logic                  wr_en_n_q, wr_en_n_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sof_err_q, sof_err_d;

    logic                  eof_w;
    logic                  take;
    logic [IDX_W-1:0]      lane;
    logic [DATA_WIDTH-1:0] word;
    logic [ADDR_WIDTH:0]   cnt_base;
    logic [ADDR_WIDTH:0]   cnt_next;

`ifdef FRAME_WR_EOF_EN
    assign eof_w = pix_eof;
`else
    assign eof_w = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pack_d       = pack_q;
        wr_en_n_d    = 1'b1;
        buf_data_d   = buf_data_q;
        words_d      = words_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;

        // A sof pixel starts a fresh word and count in either IDLE or PACK.
        // This also drops any partial word left over from an aborted frame.
        lane     = pix_sof ? '0 : idx_q;
        word     = pix_sof ? '0 : pack_q;
        word[lane*PIX_WIDTH +: PIX_WIDTH] = pix_data;
        cnt_base = pix_sof ? '0 : words_q;
        cnt_next = cnt_base + 1'b1;

        // IDLE accepts only sof pixels into a frame; all other pixels are dropped.
        take = pix_valid && ready_q &&
               ((state_q == PACK) || ((state_q == IDLE) && pix_sof));

        case (state_q)
            IDLE, PACK: begin
                if (take) begin
                    sof_err_d = pix_sof && (state_q == PACK);
                    if ((lane == LAST_IDX) || eof_w) begin
                        // Lanes above this pixel are already zero, because the
                        // packing register is cleared after every word.
                        wr_en_n_d  = 1'b0;
                        buf_data_d = word;
                        pack_d     = '0;
                        idx_d      = '0;
                        words_d    = cnt_next;
                        state_d    = ((cnt_next == FRAME_WORDS_C) || eof_w) ? DONE : PACK;
                    end else begin
                        pack_d  = word;
                        idx_d   = lane + 1'b1;
                        words_d = cnt_base;
                        state_d = PACK;
                    end
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ready stays low from the last pixel through the frame_done cycle.
        ready_d = (state_q != DONE) && (state_d != DONE);
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pack_q       <= '0;
            ready_q      <= 1'b0;
            wr_en_n_q    <= 1'b1;
            buf_data_q   <= '0;
            words_q      <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pack_q       <= pack_d;
            ready_q      <= ready_d;
            wr_en_n_q    <= wr_en_n_d;
            buf_data_q   <= buf_data_d;
            words_q      <= words_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign pix_ready     = ready_q;
    assign buf_wr_en_n   = wr_en_n_q;
    assign buf_data      = buf_data_q;
    assign words_written = words_q;
    assign frame_done    = frame_done_q;
    assign sof_err       = sof_err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_frame_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_frame_wr_packer
//
// Directed bench for frame_wr_packer (8-bit pixels, 32-bit words, 8 words per
// frame). The driver changes inputs on negedges. The monitor samples on
// negedges and records every strobe into got_q. Expected words are queued in
// exp_q and compared after each scenario.
// -----------------------------------------------------------------------------
module tb_frame_wr_packer;

    logic        wr_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data  = 8'h00;
    logic        pix_sof   = 1'b0;
    logic        pix_eof   = 1'b0;
    logic        pix_ready;
    logic        buf_wr_en_n;
    logic [31:0] buf_data;
    logic [3:0]  words_written;
    logic        frame_done;
    logic        sof_err;
    logic [1:0]  state_dbg;

    frame_wr_packer #(
        .PIX_WIDTH  (8),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3)
    ) dut (
        .wr_clk        (wr_clk),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
`ifdef FRAME_WR_EOF_EN
        .pix_eof       (pix_eof),
`endif
        .pix_ready     (pix_ready),
        .buf_wr_en_n   (buf_wr_en_n),
        .buf_data      (buf_data),
        .words_written (words_written),
        .frame_done    (frame_done),
        .sof_err       (sof_err),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 wr_clk = ~wr_clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [31:0] got_q[$];
    int          stb_cyc_q[$];
    logic [31:0] exp_q[$];
    int          fd_cnt   = 0;
    int          fd_cyc   = 0;
    logic        fd_ready = 1'b0;
    int          se_cnt   = 0;

    always @(negedge wr_clk) begin
        cyc = cyc + 1;
        if (buf_wr_en_n == 1'b0) begin
            got_q.push_back(buf_data);
            stb_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt   = fd_cnt + 1;
            fd_cyc   = cyc;
            fd_ready = pix_ready;
        end
        if (sof_err) se_cnt = se_cnt + 1;
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int stb_at(input int i);
        if (i < stb_cyc_q.size()) return stb_cyc_q[i];
        return -1000;
    endfunction

    // ---------------- driver ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge wr_clk);
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input logic eof);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        pix_eof   = eof;
        while (!pix_ready && n < 50) begin
            @(negedge wr_clk);
            n++;
        end
        if (n >= 50) check_val("ready_timeout", {31'b0, pix_ready}, 32'd1);
        @(negedge wr_clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
    endtask

    // Full frame of 32 pixels, start_val + 0..31. Optionally, one idle cycle
    // after each pixel.
    task automatic send_frame(input logic [7:0] start_val, input bit gap);
        for (int i = 0; i < 32; i++) begin
            send(start_val + 8'(i), (i == 0), 1'b0);
            if (gap) idle(1);
        end
    endtask

    task automatic expect_frame(input logic [7:0] b);
        for (int w = 0; w < 8; w++)
            exp_q.push_back({b + 8'(4*w+3), b + 8'(4*w+2), b + 8'(4*w+1), b + 8'(4*w)});
    endtask

    task automatic compare_words(input string tag, input int base);
        check_val({tag, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check_val($sformatf("%s_word%0d", tag, i), got_at(base + i), exp_q[i]);
    endtask

    // ---------------- scenarios ----------------
    int g0, f0, s0;

    initial begin
        // reset held for three cycles
        idle(3);
        check_val("rst_wr_en_n", {31'b0, buf_wr_en_n}, 32'd1);
        check_val("rst_frame_done", {31'b0, frame_done}, 32'd0);
        check_val("rst_ready", {31'b0, pix_ready}, 32'd0);
        check_val("rst_data", buf_data, 32'd0);
        check_val("rst_ww", {28'b0, words_written}, 32'd0);
        check_val("rst_sof_err", {31'b0, sof_err}, 32'd0);
        check_val("rst_state", {30'b0, state_dbg}, 32'd0);
        reset = 1'b0;
        idle(1);
        check_val("ready_after_rst", {31'b0, pix_ready}, 32'd1);

        // full frame, back to back
        g0 = got_q.size(); f0 = fd_cnt; s0 = se_cnt; exp_q.delete();
        send_frame(8'h00, 1'b0);
        expect_frame(8'h00);
        idle(4);
        compare_words("frame", g0);
        check_val("frame_first", got_at(g0), 32'h0302_0100);
        check_val("frame_last", got_at(g0 + 7), 32'h1F1E_1D1C);
        check_val("frame_done_cnt", 32'(fd_cnt - f0), 32'd1);
        check_val("frame_done_cyc", 32'(fd_cyc), 32'(stb_at(g0 + 7) + 1));
        check_val("frame_done_ready", {31'b0, fd_ready}, 32'd0);
        check_val("frame_ww", {28'b0, words_written}, 32'd8);
        check_val("frame_sof_err", 32'(se_cnt - s0), 32'd0);
        check_val("frame_b2b", 32'(stb_at(g0 + 1) - stb_at(g0)), 32'd4);

        // same frame with pix_valid low every other cycle
        g0 = got_q.size(); f0 = fd_cnt; exp_q.delete();
        send_frame(8'h00, 1'b1);
        expect_frame(8'h00);
        idle(4);
        compare_words("gap", g0);
        check_val("gap_spacing", 32'(stb_at(g0 + 1) - stb_at(g0)), 32'd8);
        check_val("gap_done_cnt", 32'(fd_cnt - f0), 32'd1);
        check_val("gap_ww", {28'b0, words_written}, 32'd8);

        // pixels without sof in IDLE are dropped
        g0 = got_q.size();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        idle(4);
        check_val("nosof_strobes", 32'(got_q.size() - g0), 32'd0);
        check_val("nosof_state", {30'b0, state_dbg}, 32'd0);
        g0 = got_q.size(); exp_q.delete();
        send_frame(8'h00, 1'b0);
        expect_frame(8'h00);
        idle(4);
        compare_words("after_drop", g0);

        // mid-frame sof on the 6th pixel
        g0 = got_q.size(); s0 = se_cnt; exp_q.delete();
        send(8'h30, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send(8'h30 + 8'(i), 1'b0, 1'b0);
        send(8'h40, 1'b1, 1'b0);
        check_val("abort_ww", {28'b0, words_written}, 32'd0);
        send(8'h41, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b0, 1'b0);
        idle(4);
        exp_q.push_back(32'h3332_3130);
        exp_q.push_back(32'h4342_4140);
        compare_words("abort", g0);
        check_val("abort_sof_err", 32'(se_cnt - s0), 32'd1);
        check_val("abort_ww_after", {28'b0, words_written}, 32'd1);

        // reset after three words and a partial one
        g0 = got_q.size(); exp_q.delete();
        for (int i = 0; i < 14; i++) send(8'h50 + 8'(i), (i == 0), 1'b0);
        reset = 1'b1;
        idle(3);
        check_val("midrst_ww", {28'b0, words_written}, 32'd0);
        check_val("midrst_state", {30'b0, state_dbg}, 32'd0);
        check_val("midrst_wr_en_n", {31'b0, buf_wr_en_n}, 32'd1);
        reset = 1'b0;
        idle(2);
        exp_q.push_back(32'h5352_5150);
        exp_q.push_back(32'h5756_5554);
        exp_q.push_back(32'h5B5A_5958);
        compare_words("midrst", g0);
        g0 = got_q.size(); f0 = fd_cnt; exp_q.delete();
        send_frame(8'h60, 1'b0);
        expect_frame(8'h60);
        idle(4);
        compare_words("post_rst", g0);
        check_val("post_rst_done", 32'(fd_cnt - f0), 32'd1);

`ifdef FRAME_WR_EOF_EN
        // early end of frame with a zero-padded last word
        g0 = got_q.size(); f0 = fd_cnt; exp_q.delete();
        for (int i = 0; i < 5; i++) send(8'(i), (i == 0), 1'b0);
        send(8'h05, 1'b0, 1'b1);
        idle(4);
        exp_q.push_back(32'h0302_0100);
        exp_q.push_back(32'h0000_0504);
        compare_words("eof", g0);
        check_val("eof_done", 32'(fd_cnt - f0), 32'd1);
        check_val("eof_ww", {28'b0, words_written}, 32'd2);

        // eof on a word boundary gives no extra padding word
        g0 = got_q.size(); f0 = fd_cnt; exp_q.delete();
        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), (i == 0), 1'b0);
        send(8'h17, 1'b0, 1'b1);
        idle(4);
        exp_q.push_back(32'h1312_1110);
        exp_q.push_back(32'h1716_1514);
        compare_words("eof_edge", g0);
        check_val("eof_edge_ww", {28'b0, words_written}, 32'd2);

        // sof together with eof gives a one-pixel frame
        g0 = got_q.size(); f0 = fd_cnt; exp_q.delete();
        send(8'h77, 1'b1, 1'b1);
        idle(4);
        exp_q.push_back(32'h0000_0077);
        compare_words("onepix", g0);
        check_val("onepix_done", 32'(fd_cnt - f0), 32'd1);
        check_val("onepix_ww", {28'b0, words_written}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
